// File: rtl/clock_disp_pkg.sv
// rtl/clock_disp_pkg.sv - shared constants for the clock display scanner
// Seven-segment patterns are {g,f,e,d,c,b,a}, active-high.
// Digit indices follow the scan order: secL is scanned first, hourH last.
package clock_disp_pkg;

    typedef logic [2:0] dig_idx_t;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [7:0] SEG_OFF  = 8'h00;

    localparam dig_idx_t DIG_SECL  = 3'd0;
    localparam dig_idx_t DIG_SECH  = 3'd1;
    localparam dig_idx_t DIG_MINL  = 3'd2;
    localparam dig_idx_t DIG_MINH  = 3'd3;
    localparam dig_idx_t DIG_HOURL = 3'd4;
    localparam dig_idx_t DIG_HOURH = 3'd5;

    localparam logic [5:0] DIG_OFF = 6'b111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - BCD digit to seven-segment pattern decoder
// Ports:
//   i_bcd  in  4  BCD value
//   o_seg  out 7  {g,f,e,d,c,b,a}, active-high; 10-15 decode to a dash so
//                 corrupt counter values stay visible on the display
module bcd_to_seg7
    import clock_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/clock_disp_scan.sv
// rtl/clock_disp_scan.sv - multiplexed 6-digit common-anode display scanner
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   enable                         low = display dark and scan frozen
//   hourH..secL        in  4 each  BCD digits, indices 5..0
//   blink_mask         in  6       bit i set: digit i blinks
//   blank_lead         in  1       suppress a leading zero in hourH
//   dp_en              in  1       decimal points on digits 4 and 2
//   seg                out 8       {dp,g,f,e,d,c,b,a}, active-high
//   dig_sel            out 6       one-hot digit enable, active-low
module clock_disp_scan
    import clock_disp_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       enable,
    input  logic [3:0] hourH,
    input  logic [3:0] hourL,
    input  logic [3:0] minH,
    input  logic [3:0] minL,
    input  logic [3:0] secH,
    input  logic [3:0] secL,
    input  logic [5:0] blink_mask,
    input  logic       blank_lead,
    input  logic       dp_en,
    output logic [7:0] seg,
    output logic [5:0] dig_sel
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [FR_W-1:0]  FR_MAX  = FR_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] r_cnt;
    dig_idx_t         r_idx;
    logic [FR_W-1:0]  r_frame_cnt;
    logic             r_blink_phase;

    // Frame-wide copies of every display input, so a frame never tears.
    logic [5:0][3:0]  r_snap_dig;
    logic [5:0]       r_snap_mask;
    logic             r_snap_blank_lead;
    logic             r_snap_dp_en;

    logic [7:0]       r_seg;
    logic [5:0]       r_dig_sel;

    logic             w_tick;
    logic             w_frame_end;
    logic [3:0]       w_cur_bcd;
    logic [6:0]       w_seg7;
    logic             w_blank;
    logic             w_dp;

    assign w_tick      = enable && (r_cnt == CNT_MAX);
    assign w_frame_end = w_tick && (r_idx == DIG_HOURH);
    assign w_cur_bcd   = r_snap_dig[r_idx];

    // Blink takes priority over leading-zero suppression; both leave the
    // digit strobe active so scan timing is unchanged.
    assign w_blank = (r_blink_phase && r_snap_mask[r_idx]) ||
                     ((r_idx == DIG_HOURH) && r_snap_blank_lead &&
                      (r_snap_dig[DIG_HOURH] == 4'd0));
    assign w_dp    = r_snap_dp_en && ((r_idx == DIG_HOURL) || (r_idx == DIG_MINL)) && !w_blank;

    bcd_to_seg7 u_dec (
        .i_bcd (w_cur_bcd),
        .o_seg (w_seg7)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt         <= '0;
            r_idx         <= DIG_SECL;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (enable) begin
            if (w_tick) begin
                r_cnt <= '0;
                r_idx <= (r_idx == DIG_HOURH) ? DIG_SECL : r_idx + 3'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_frame_end) begin
                if (r_frame_cnt == FR_MAX) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_snap_dig        <= '0;
            r_snap_mask       <= '0;
            r_snap_blank_lead <= 1'b0;
            r_snap_dp_en      <= 1'b0;
        end else if (w_frame_end) begin
            r_snap_dig        <= {hourH, hourL, minH, minL, secH, secL};
            r_snap_mask       <= blink_mask;
            r_snap_blank_lead <= blank_lead;
            r_snap_dp_en      <= dp_en;
        end
    end

    // The first cycle of each slot is dark so the previous digit's
    // segments cannot ghost onto the newly selected anode.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dig_sel <= DIG_OFF;
            r_seg     <= SEG_OFF;
        end else if (!enable || (r_cnt == '0)) begin
            r_dig_sel <= DIG_OFF;
            r_seg     <= SEG_OFF;
        end else begin
            r_dig_sel <= ~(6'b000001 << r_idx);
            r_seg     <= w_blank ? SEG_OFF : {w_dp, w_seg7};
        end
    end

    assign seg     = r_seg;
    assign dig_sel = r_dig_sel;

endmodule

// File: tb/tb_clock_disp_scan.sv
// tb/tb_clock_disp_scan.sv - directed testbench for clock_disp_scan
module tb_clock_disp_scan;

    logic       clk = 1'b0;
    logic       rstn;
    logic       enable;
    logic [3:0] hourH, hourL, minH, minL, secH, secL;
    logic [5:0] blink_mask;
    logic       blank_lead;
    logic       dp_en;
    logic [7:0] seg;
    logic [5:0] dig_sel;

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [5:0] DIG_ON [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    localparam logic [13:0] DARK = {6'h3F, 8'h00};
    localparam logic [47:0] NORMAL = 48'h06_5B_4F_66_6D_7D;
    localparam logic [47:0] BLINKED = 48'h06_5B_4F_66_00_00;
    localparam logic [47:0] NEW_MINL = 48'h06_5B_4F_6F_6D_7D;

    always #5 clk = ~clk;

    clock_disp_scan #(
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .hourH      (hourH),
        .hourL      (hourL),
        .minH       (minH),
        .minL       (minL),
        .secH       (secH),
        .secL       (secL),
        .blink_mask (blink_mask),
        .blank_lead (blank_lead),
        .dp_en      (dp_en),
        .seg        (seg),
        .dig_sel    (dig_sel)
    );

    task automatic chk(input string tag, input logic [13:0] act, input logic [13:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got dig_sel/seg %h want %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic digit_cycles(input string tag, input int s, input logic [7:0] e, input int n);
        for (int k = 0; k < n; k++) begin
            step();
            chk(tag, {dig_sel, seg}, {DIG_ON[s], e});
        end
    endtask

    task automatic guard_cycle(input string tag);
        step();
        chk({tag, " guard"}, {dig_sel, seg}, DARK);
    endtask

    task automatic run_slot(input string tag, input int s, input logic [7:0] e);
        guard_cycle(tag);
        digit_cycles(tag, s, e, 3);
    endtask

    task automatic run_slots(input string tag, input int first, input int last, input logic [47:0] e);
        for (int s = first; s <= last; s++)
            run_slot($sformatf("%s s%0d", tag, s), s, e[s*8 +: 8]);
    endtask

    task automatic set_time(input logic [3:0] h1, h0, m1, m0, s1, s0);
        hourH = h1; hourL = h0; minH = m1; minL = m0; secH = s1; secL = s0;
    endtask

    initial begin
        rstn = 1'b0;
        enable = 1'b0;
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        blink_mask = 6'b0;
        blank_lead = 1'b0;
        dp_en = 1'b0;
        step();
        step();
        chk("reset", {dig_sel, seg}, DARK);
        rstn = 1'b1;
        step();
        step();
        chk("idle disabled", {dig_sel, seg}, DARK);

        enable = 1'b1;
        run_slots("f1 zeros", 0, 5, {6{8'h3F}});
        hourH = 4'd0;
        blank_lead = 1'b1;
        run_slots("f2 digits", 0, 5, NORMAL);
        blank_lead = 1'b0;
        hourL = 4'hC;
        dp_en = 1'b1;
        run_slots("f3 lead blank", 0, 5, 48'h00_5B_4F_66_6D_7D);
        hourH = 4'd1;
        hourL = 4'd2;
        dp_en = 1'b0;
        blink_mask = 6'b000011;
        run_slots("f4 dash dp", 0, 5, 48'h3F_C0_4F_E6_6D_7D);
        run_slots("f5 blink vis", 0, 5, NORMAL);
        run_slots("f6 blink vis", 0, 5, NORMAL);
        run_slots("f7 blink off", 0, 5, BLINKED);
        run_slots("f8 blink off", 0, 5, BLINKED);

        run_slots("f9 pre", 0, 1, NORMAL);
        minL = 4'd9;
        run_slots("f9 held", 2, 5, NORMAL);
        blink_mask = 6'b0;
        run_slots("f10 new minL", 0, 5, NEW_MINL);

        run_slots("f11", 0, 0, NEW_MINL);
        guard_cycle("f11 s1");
        digit_cycles("f11 s1 pre-pause", 1, 8'h6D, 1);
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("paused c%0d", k), {dig_sel, seg}, DARK);
        end
        enable = 1'b1;
        digit_cycles("f11 s1 resumed", 1, 8'h6D, 2);
        run_slots("f11 post", 2, 5, NEW_MINL);

        run_slots("f12", 0, 0, NEW_MINL);
        guard_cycle("f12 s1");
        digit_cycles("f12 s1", 1, 8'h6D, 1);
        rstn = 1'b0;
        #1;
        chk("async reset", {dig_sel, seg}, DARK);
        step();
        chk("reset held", {dig_sel, seg}, DARK);
        rstn = 1'b1;
        run_slots("post reset", 0, 1, {6{8'h3F}});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
